// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the DataMemory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_EXT  = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned BEAT_W = 8;

  // Access size encoding understood by DataMemory
  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, external-requester and DataMemory signals around the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wd;
  logic [1:0]        core_mask_type;
  logic              core_ext_type;
  logic              core_stall;
  logic [DATA_W-1:0] core_rd;

  logic              ext_req;
  logic              ext_we;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wd;
  logic [1:0]        ext_mask_type;
  logic              ext_ext_type;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rd;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [1:0]        mem_mask_type;
  logic              mem_ext_type;
  logic [DATA_W-1:0] mem_rd;

  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_ext_cnt;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wd, core_mask_type, core_ext_type,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wd, ext_mask_type, ext_ext_type,
    input  mem_rd,
    output core_stall, core_rd, ext_gnt, ext_rd,
    output mem_we, mem_addr, mem_wd, mem_mask_type, mem_ext_type,
    output perf_stall_cnt, perf_ext_cnt
  );

  // Requester / memory environment side
  modport master (
    output core_req, core_we, core_addr, core_wd, core_mask_type, core_ext_type,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wd, ext_mask_type, ext_ext_type,
    output mem_rd,
    input  core_stall, core_rd, ext_gnt, ext_rd,
    input  mem_we, mem_addr, mem_wd, mem_mask_type, mem_ext_type,
    input  perf_stall_cnt, perf_ext_cnt
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-request round-robin grant; force-core overrides the rotation.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic   i_req_core,
  input  logic   i_req_ext,
  input  owner_e i_last_owner,
  input  logic   i_force_core,
  output logic   o_gnt_core_c,
  output logic   o_gnt_ext_c
);

  always_comb begin
    o_gnt_core_c = 1'b0;
    o_gnt_ext_c  = 1'b0;
    if (i_req_core && i_req_ext) begin
      if (i_force_core || (i_last_owner == OWNER_EXT)) o_gnt_core_c = 1'b1;
      else                                              o_gnt_ext_c  = 1'b1;
    end else begin
      o_gnt_core_c = i_req_core;
      o_gnt_ext_c  = i_req_ext;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DataMemory port between the core and an external requester, with locked bursts.
// Optional performance counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam bit               LOCK_EN    = (MAX_BURST > 1);
  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(MAX_BURST - 1);

  arb_state_e        r_state;
  owner_e            r_last_owner;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_yield;

  logic              w_idle_gnt_core;
  logic              w_idle_gnt_ext;
  logic              w_gnt_core;
  logic              w_gnt_ext;
  logic              w_core_stall;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wd;
  logic [1:0]        w_mem_mask_type;
  logic              w_mem_ext_type;

  rr_arbiter2 u_rr (
    .i_req_core   (bus.core_req),
    .i_req_ext    (bus.ext_req),
    .i_last_owner (r_last_owner),
    .i_force_core (r_yield),
    .o_gnt_core_c (w_idle_gnt_core),
    .o_gnt_ext_c  (w_idle_gnt_ext)
  );

  // A locked burst owns the port outright; the core cannot cut in
  always_comb begin
    w_gnt_core = 1'b0;
    w_gnt_ext  = 1'b0;
    if (r_state == ARB_LOCKED) begin
      w_gnt_ext = bus.ext_req;
    end else begin
      w_gnt_core = w_idle_gnt_core;
      w_gnt_ext  = w_idle_gnt_ext;
    end
  end

  // Core values park on the bus when nobody is granted
  always_comb begin
    w_mem_we        = 1'b0;
    w_mem_addr      = bus.core_addr;
    w_mem_wd        = bus.core_wd;
    w_mem_mask_type = bus.core_mask_type;
    w_mem_ext_type  = bus.core_ext_type;
    if (w_gnt_ext) begin
      w_mem_we        = bus.ext_we;
      w_mem_addr      = bus.ext_addr;
      w_mem_wd        = bus.ext_wd;
      w_mem_mask_type = bus.ext_mask_type;
      w_mem_ext_type  = bus.ext_ext_type;
    end else if (w_gnt_core) begin
      w_mem_we = bus.core_we;
    end
  end

  assign w_core_stall       = bus.core_req && !w_gnt_core;
  assign bus.core_stall     = w_core_stall;
  assign bus.ext_gnt        = w_gnt_ext;
  assign bus.core_rd        = bus.mem_rd;
  assign bus.ext_rd         = bus.mem_rd;
  assign bus.mem_we         = w_mem_we;
  assign bus.mem_addr       = w_mem_addr;
  assign bus.mem_wd         = w_mem_wd;
  assign bus.mem_mask_type  = w_mem_mask_type;
  assign bus.mem_ext_type   = w_mem_ext_type;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= OWNER_EXT;
      r_beat_cnt   <= '0;
      r_yield      <= 1'b0;
    end else begin
      if (w_gnt_core || w_gnt_ext) r_last_owner <= w_gnt_ext ? OWNER_EXT : OWNER_CORE;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_core || !bus.core_req) r_yield <= 1'b0;
          if (w_gnt_ext && bus.ext_lock && LOCK_EN) begin
            r_state    <= ARB_LOCKED;
            r_beat_cnt <= BEAT_W'(1);
          end
        end
        ARB_LOCKED: begin
          // Forced release hands the next tie to a waiting core
          if (w_gnt_ext) begin
            if (!bus.ext_lock || (r_beat_cnt == BURST_LAST)) begin
              r_state    <= ARB_IDLE;
              r_beat_cnt <= '0;
              r_yield    <= bus.core_req;
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
          end else if (!bus.ext_lock) begin
            r_state    <= ARB_IDLE;
            r_beat_cnt <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_ext_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_ext_cnt   <= '0;
    end else begin
      if (w_core_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_gnt_ext)    r_perf_ext_cnt   <= r_perf_ext_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_ext_cnt   = r_perf_ext_cnt;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_ext_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-granular DataMemory stand-in with combinational read
  logic [31:0] mem [0:63];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 32'h0;
    bus.core_wd = 32'h0; bus.core_mask_type = MASK_WORD; bus.core_ext_type = 1'b0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_lock = 1'b0; bus.ext_addr = 32'h0;
    bus.ext_wd = 32'h0; bus.ext_mask_type = MASK_WORD; bus.ext_ext_type = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  // Leaves last_owner = core so the next tie goes to the external side
  task automatic core_only_cycle();
    bus.core_req = 1'b1; bus.core_addr = 32'h4; bus.core_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_core_stall: got %b expected 0", bus.core_stall); end
    n_checks++; if (bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ext_gnt: got %b expected 0", bus.ext_gnt); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.perf_stall_cnt !== 32'd0 || bus.perf_ext_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", bus.perf_stall_cnt, bus.perf_ext_cnt); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_core_store_load();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h10; bus.core_wd = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b expected 0", bus.core_stall); end
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL store_mem_we: got %b expected 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL store_mem_addr: got %h expected 00000010", bus.mem_addr); end
    tick();
    bus.core_we = 1'b0;
    #1;
    n_checks++; if (bus.core_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_core_rd: got %h expected deadbeef", bus.core_rd); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_we: got %b expected 0", bus.mem_we); end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic core_turn;
    apply_reset();
    bus.core_req = 1'b1; bus.core_addr = 32'h10;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h20; bus.ext_wd = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      core_turn = (i % 2) == 0;
      #1;
      n_checks++; if (bus.core_stall !== !core_turn) begin n_fail++; $display("FAIL rr_stall[%0d]: got %b expected %b", i, bus.core_stall, !core_turn); end
      n_checks++; if (bus.ext_gnt !== !core_turn) begin n_fail++; $display("FAIL rr_ext_gnt[%0d]: got %b expected %b", i, bus.ext_gnt, !core_turn); end
      n_checks++; if (bus.mem_addr !== (core_turn ? 32'h10 : 32'h20)) begin n_fail++; $display("FAIL rr_mem_addr[%0d]: got %h", i, bus.mem_addr); end
      n_checks++; if (bus.mem_we !== !core_turn) begin n_fail++; $display("FAIL rr_mem_we[%0d]: got %b expected %b", i, bus.mem_we, !core_turn); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_locked_burst();
    logic exp_ext;
    apply_reset();
    core_only_cycle();
    bus.core_req = 1'b1; bus.ext_req = 1'b1; bus.ext_lock = 1'b1; bus.ext_addr = 32'h40;
    for (int i = 1; i <= 10; i++) begin
      exp_ext = (i != 9);
      #1;
      n_checks++; if (bus.ext_gnt !== exp_ext) begin n_fail++; $display("FAIL burst_ext_gnt[%0d]: got %b expected %b", i, bus.ext_gnt, exp_ext); end
      n_checks++; if (bus.core_stall !== exp_ext) begin n_fail++; $display("FAIL burst_stall[%0d]: got %b expected %b", i, bus.core_stall, exp_ext); end
      if (i == 10) begin
`ifdef DMEM_ARB_PERF_EN
        n_checks++; if (bus.perf_stall_cnt !== 32'd8) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d expected 8", bus.perf_stall_cnt); end
        n_checks++; if (bus.perf_ext_cnt !== 32'd8) begin n_fail++; $display("FAIL perf_ext_cnt: got %0d expected 8", bus.perf_ext_cnt); end
`else
        n_checks++; if (bus.perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d expected 0", bus.perf_stall_cnt); end
        n_checks++; if (bus.perf_ext_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_ext_cnt: got %0d expected 0", bus.perf_ext_cnt); end
`endif
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst_hole();
    logic exp_ext;
    apply_reset();
    core_only_cycle();
    bus.core_req = 1'b1; bus.ext_lock = 1'b1; bus.ext_addr = 32'h44;
    // 3 beats, 2-cycle hole, 5 remaining beats, then the core
    for (int i = 0; i < 11; i++) begin
      bus.ext_req = !(i == 3 || i == 4);
      exp_ext = !(i == 3 || i == 4 || i == 10);
      #1;
      n_checks++; if (bus.ext_gnt !== exp_ext) begin n_fail++; $display("FAIL hole_ext_gnt[%0d]: got %b expected %b", i, bus.ext_gnt, exp_ext); end
      n_checks++; if (bus.core_stall !== (i != 10)) begin n_fail++; $display("FAIL hole_stall[%0d]: got %b expected %b", i, bus.core_stall, i != 10); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock_release();
    apply_reset();
    core_only_cycle();
    bus.core_req = 1'b1; bus.ext_req = 1'b1; bus.ext_lock = 1'b1;
    tick();
    tick();
    bus.ext_lock = 1'b0;
    #1;
    n_checks++; if (bus.ext_gnt !== 1'b1) begin n_fail++; $display("FAIL release_last_beat: got %b expected 1", bus.ext_gnt); end
    tick();
    n_checks++; if (bus.core_stall !== 1'b0 || bus.ext_gnt !== 1'b0) begin
      n_fail++; $display("FAIL release_core_next: got stall=%b gnt=%b expected 0/0", bus.core_stall, bus.ext_gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    core_only_cycle();
    bus.core_req = 1'b1; bus.ext_req = 1'b1; bus.ext_lock = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_stall: got %b expected 1", bus.core_stall); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_ext_gnt: got %b expected 0", bus.ext_gnt); end
    n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", bus.core_stall); end
    bus.ext_req = 1'b0; bus.ext_lock = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_lone_core: got %b expected 0", bus.core_stall); end
    tick();
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_core_store_load();
    test_round_robin();
    test_locked_burst();
    test_burst_hole();
    test_lock_release();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single DataMemory port between the core load/store path and an external requester (boot loader / DMA / debug).
- Sits between the datapath's ALU-result, rs2 and mask signals and DataMemory.
- Grants same-cycle access, stalls the core while the external side owns the port, and supports locked external bursts with a forced-release bound.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, write/read data width.
- MAX_BURST, 8, maximum consecutive granted external beats under lock before forced release; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core performs a load/store this cycle.
- core_we  in  1  core store.
- core_addr  in  ADDR_W  core address (ALU result).
- core_wd  in  DATA_W  core store data (rs2).
- core_mask_type  in  2  byte/half/word select.
- core_ext_type  in  1  sign/zero extend for loads.
- core_stall  out  1  core_req not granted; PC and register write must hold.
- core_rd  out  DATA_W  load data to the result mux.
- ext_req  in  1  external access request.
- ext_we  in  1  external write.
- ext_lock  in  1  request to hold the port across beats.
- ext_addr  in  ADDR_W  external address.
- ext_wd  in  DATA_W  external write data.
- ext_mask_type  in  2  external mask type.
- ext_ext_type  in  1  external extension type.
- ext_gnt  out  1  external access performed this cycle.
- ext_rd  out  DATA_W  external read data, valid when ext_gnt && !ext_we.
- mem_we  out  1  to DataMemory i_we.
- mem_addr  out  ADDR_W  to i_addr.
- mem_wd  out  DATA_W  to i_wd.
- mem_mask_type  out  2  to i_mask_type.
- mem_ext_type  out  1  to i_ext_type.
- mem_rd  in  DATA_W  from o_rd (combinational read).
- perf_stall_cnt  out  32  core stall cycle count (see Optional Feature).
- perf_ext_cnt  out  32  granted external beat count (see Optional Feature).

Behaviour:
- State register: IDLE, LOCKED. Registers: last_owner (0 = core, 1 = ext), beat_cnt (8 bit), yield flag.
- Reset (rst = 0, asynchronous): state = IDLE, last_owner = ext (so the core wins the first tie), beat_cnt = 0, yield = 0. Outputs are combinational; with no requests, core_stall = 0, ext_gnt = 0, mem_we = 0.
- Grant is combinational on the same cycle; there are no wait states and read latency is 0.
- IDLE grant rules:
  - Only one requester: it is granted.
  - Both requesting: the owner != last_owner wins (round-robin).
  - yield = 1: the core wins regardless of last_owner.
- LOCKED grant rules: ext_req granted unconditionally; core_stall = core_req.
- Mux: the granted side drives mem_*. mem_we = granted side's we, else 0. With no grant, mem_addr/mem_wd hold the core values and mem_we = 0.
- core_rd = ext_rd = mem_rd, unconditional wiring; validity is given by grant.
- core_stall = core_req && !core_granted. ext_gnt = ext granted.
- last_owner updates on each cycle with a grant; it holds when there is no grant.
- IDLE -> LOCKED: ext granted && ext_lock && MAX_BURST > 1; beat_cnt <= 1.
- LOCKED, ext granted:
  - beat_cnt++.
  - If ext_lock = 0 or beat_cnt + 1 == MAX_BURST: go to IDLE, beat_cnt <= 0, yield <= core_req.
- LOCKED, ext_req = 0: remain LOCKED (idle hole in the burst); beat_cnt holds; the core stays stalled.
- LOCKED, ext_lock = 0 && ext_req = 0: go to IDLE; no beat counted.
- yield clears on the first cycle the core is granted, or when core_req = 0 in IDLE.
- MAX_BURST = 1: lock is ignored and the arbiter never enters LOCKED.
- Simultaneous ext_lock release and core_req: the core is granted the next cycle.
- Reset mid-burst: returns to IDLE immediately; the in-flight write is not guaranteed.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle core_stall = 1.
  - perf_ext_cnt increments each ext_gnt cycle.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesised; the port list is unchanged.

Decomposition:
- Shared package dmem_arb_pkg: owner_e enum (OWNER_CORE, OWNER_EXT), arb_state_e (ARB_IDLE, ARB_LOCKED), MASK_* constants shared with DataMemory.
- One sub-module: rr_arbiter2, a two-request round-robin grant with a last_owner input and a force-core input.
- The datapath mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset, core_req=1, core_we=1, addr=0x10, wd=0xDEADBEEF -> core_stall=0, mem_we=1, mem_addr=0x10. Next cycle: load 0x10 -> core_rd=0xDEADBEEF.
- core_req and ext_req both held 4 cycles, no lock, after reset -> grants alternate core, ext, core, ext; core_stall=0,1,0,1.
- MAX_BURST=8, ext_lock=1, ext_req held 10 cycles, core_req=1 -> ext_gnt for exactly 8 cycles, then core granted on cycle 9 (yield), core_stall=1 for cycles 1-8.
- Locked burst with ext_req=0 at beat 3 for 2 cycles -> state stays LOCKED, beat_cnt holds at 3, core_stall=1 throughout.
- Assert rst=0 asynchronously mid-burst (beat 5) -> state IDLE immediately; after release a lone core_req is granted with core_stall=0.
- With DMEM_ARB_PERF_EN, the third scenario -> perf_stall_cnt=8, perf_ext_cnt=8. Without the macro -> both read 0.
